// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes and frame geometry.
// Intended to be imported by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        REPOSO,
        INICIO,
        DATOS,
        PARIDAD_B,
        PARO
    } estado_t;

    localparam int PAR_CERO    = 0;
    localparam int PAR_PAR     = 1;
    localparam int PAR_IMPAR   = 2;
    localparam int PAR_NINGUNA = 3;

    localparam int BITS_DATO = 8;
    localparam int IDX_W     = $clog2(BITS_DATO);

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle (high) level.
module sincronizador (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        // NOTE: reset to 1 (line idle) so leaving reset never looks like a start edge.
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/receptor_uart.sv
// UART receiver: mid-bit sampling at CLKS_PER_BIT, 8 data bits LSB first,
// optional parity, one stop bit; one-cycle listo pulse with error flags.
module receptor_uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARIDAD      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entradaRx,
    output logic [7:0] datoRx,
    output logic       listo,
    output logic       errParidad,
    output logic       errTrama,
    output logic       ocupado
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MEDIO = CW'(H - 1);
    localparam logic [CW-1:0] CNT_BIT   = CW'(CLKS_PER_BIT - 1);

    logic                 rxs, rxs_prev;
    estado_t              estado, estado_sig;
    logic [CW-1:0]        cnt, cnt_sig;
    logic [IDX_W-1:0]     idx, idx_sig;
    logic [BITS_DATO-1:0] shift, shift_sig;
    logic                 par_err, par_err_sig;
    logic                 esperado;
    logic [7:0]           dato_sig;
    logic                 listo_sig, errp_sig, errt_sig;

    sincronizador u_sinc (
        .clk   (clk),
        .reset (reset),
        .d     (entradaRx),
        .q     (rxs)
    );

    always_comb begin
        case (PARIDAD)
            PAR_PAR:   esperado = ^shift;
            PAR_IMPAR: esperado = ~^shift;
            default:   esperado = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        estado_sig  = estado;
        cnt_sig     = cnt + 1'b1;
        idx_sig     = idx;
        shift_sig   = shift;
        par_err_sig = par_err;
        listo_sig   = 1'b0;
        dato_sig    = datoRx;
        errp_sig    = errParidad;
        errt_sig    = errTrama;

        case (estado)
            REPOSO: begin
                cnt_sig = '0;
                if (rxs_prev && !rxs) estado_sig = INICIO;
            end
            INICIO: begin
                if (cnt == CNT_MEDIO) begin
                    cnt_sig    = '0;
                    idx_sig    = '0;
                    estado_sig = rxs ? REPOSO : DATOS;
                end
            end
            DATOS: begin
                if (cnt == CNT_BIT) begin
                    cnt_sig        = '0;
                    shift_sig[idx] = rxs;
                    if (idx == IDX_W'(BITS_DATO - 1))
                        estado_sig = (PARIDAD == PAR_NINGUNA) ? PARO : PARIDAD_B;
                    else
                        idx_sig = idx + 1'b1;
                end
            end
            PARIDAD_B: begin
                if (cnt == CNT_BIT) begin
                    cnt_sig     = '0;
                    par_err_sig = rxs ^ esperado;
                    estado_sig  = PARO;
                end
            end
            PARO: begin
                if (cnt == CNT_BIT) begin
                    cnt_sig    = '0;
                    estado_sig = REPOSO;
                    listo_sig  = 1'b1;
                    dato_sig   = shift;
                    errt_sig   = ~rxs;
                    errp_sig   = (PARIDAD == PAR_NINGUNA) ? 1'b0 : par_err;
                end
            end
            default: estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado     <= REPOSO;
            rxs_prev   <= 1'b1;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par_err    <= 1'b0;
            listo      <= 1'b0;
            datoRx     <= '0;
            errParidad <= 1'b0;
            errTrama   <= 1'b0;
        end else begin
            estado     <= estado_sig;
            rxs_prev   <= rxs;
            cnt        <= cnt_sig;
            idx        <= idx_sig;
            shift      <= shift_sig;
            par_err    <= par_err_sig;
            listo      <= listo_sig;
            datoRx     <= dato_sig;
            errParidad <= errp_sig;
            errTrama   <= errt_sig;
        end
    end

    assign ocupado = (estado != REPOSO);

endmodule

// File: doc/receptor_uart.md
# receptor_uart

- Serial receiver for the UART link: recovers 8-bit bytes from the serial line by mid-bit sampling at a fixed clocks-per-bit rate.
- Checks the parity bit and the stop bit, and presents each byte with a one-cycle valid pulse and error flags.
- Sits at the RX pin, opposite the team's UART transmitter, and uses the same frame: start 0, data LSB first, parity, stop 1.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 4. H = CLKS_PER_BIT/2, integer division.
- PARIDAD, 0, parity mode:
  - 0 = parity bit must be 0 (fixed, matches the current transmitter).
  - 1 = even parity.
  - 2 = odd parity.
  - 3 = no parity bit.

Ports (clock and reset first; one clock; reset is synchronous and active-low):
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- entradaRx  input  1  asynchronous serial line; idles high.
- datoRx  output  8  last received byte; changes only in the cycle `listo` is high.
- listo  output  1  one-cycle pulse marking the end of a frame.
- errParidad  output  1  parity mismatch for the frame flagged by `listo`.
- errTrama  output  1  stop bit sampled 0 for the frame flagged by `listo`.
- ocupado  output  1  high whenever the FSM is not in REPOSO.

## Operation
- **Synchronizer:** `entradaRx` passes through 2 flops to give `rxs`; a third flop holds `rxs_prev`.
- **FSM states:** REPOSO, INICIO, DATOS, PARIDAD_B, PARO.
- **REPOSO:** a falling edge (`rxs_prev`=1, `rxs`=0) loads the cycle counter with 0 and moves to INICIO. A line that stays low does not retrigger.
- **INICIO:** at count H-1, sample `rxs`.
  - 0: clear the counter and bit index, go to DATOS.
  - 1: false start; return to REPOSO, no `listo`.
- **DATOS:** every CLKS_PER_BIT cycles, sample `rxs` into shift bit [index], LSB first. After index 7, go to PARIDAD_B, or to PARO if PARIDAD=3.
- **PARIDAD_B:** sample one bit and compare with the expected value:
  - mode 0: expected 0.
  - mode 1: expected XOR of data.
  - mode 2: expected ~XOR of data.
- **PARO:** sample one bit, then:
  - `errTrama` = ~sample.
  - `datoRx` = shift register.
  - pulse `listo`.
  - return to REPOSO in the same transition.
- **Error flags:** `listo` fires for every completed frame, errored or not. Errors do not suppress the data update. Flags hold their value until the next `listo`.
- **Mode 3:** `errParidad` is always 0.
- **Line still low after a framing error:** no new start is detected until `rxs` goes high and then falls again.
- **Counter:** width is clog2(CLKS_PER_BIT). It wraps to 0 at each sample point.

## Timing
- **Reset values** (when `reset`=0 at a rising edge):
  - datoRx=0x00, listo=0, errParidad=0, errTrama=0, ocupado=0.
  - FSM in REPOSO.
  - synchronizer flops and `rxs_prev`=1.
- **Reset mid-frame:** the frame is abandoned with no `listo`. Reception resumes on the next falling edge after reset is released.
- **t0 definition:** t0 = the cycle in which the edge detector sees the fall. This is 2 cycles after the pin falls, plus the clock-phase uncertainty of the synchronizer.
- **Sample points:**
  - start bit at t0+H.
  - data bit i at t0+H+(i+1)·CLKS_PER_BIT.
  - parity at t0+H+9·CLKS_PER_BIT.
  - stop at t0+H+10·CLKS_PER_BIT (9· when PARIDAD=3).
- **Outputs:**
  - `listo`, `datoRx`, and the error flags update on the clock edge following the stop sample. `listo` is high for exactly 1 cycle.
  - `ocupado` rises the cycle after t0 and falls with the `listo` edge.
- **Back-to-back frames:** a new start edge is accepted from the first cycle back in REPOSO. A next start bit arriving half a bit after the stop-bit centre is captured without loss.
- **Baud tolerance:** the sample point may drift up to ±H−1 cycles over the frame.

## Structure
- **Package `uart_pkg`:**
  - state encoding enum.
  - PARIDAD mode constants (PAR_CERO, PAR_PAR, PAR_IMPAR, PAR_NINGUNA).
  - frame length constants (8 data bits).
  - later shared with the transmitter.
- **Sub-module `sincronizador`:** 2-flop synchronizer with reset value 1. It is instantiated once.
- **Top level:** the remainder (FSM, counter, shift register, parity XOR, output registers) lives in `receptor_uart`.

## Test plan
- **Byte 0xA5, PARIDAD=0, CLKS_PER_BIT=16, parity bit 0, stop 1:**
  - → `listo` 1 cycle, `datoRx`=0xA5, errParidad=0, errTrama=0.
  - `listo` occurs at t0+H+160+1 cycles.
- **0x03, PARIDAD=1, parity bit sent 1** (wrong; expected 0) → `datoRx`=0x03, errParidad=1. Next frame 0x03 with parity bit 0 → errParidad=0.
- **Glitch: line low for 5 cycles, then high** → no `listo`, `ocupado` returns to 0 after H cycles. A following valid 0x5A frame → `datoRx`=0x5A.
- **0xFF with stop bit forced 0, line held low for 3 bits, then high, then 0x11** → first `listo` with errTrama=1 and `datoRx`=0xFF. No spurious frame while the line is low. Second `listo` with `datoRx`=0x11, errTrama=0.
- **Back-to-back: 0x00, 0xFF, 0x81 with no idle gap, PARIDAD=3** → three `listo` pulses, each 9.5·16 cycles after its frame's start edge, with the data in order.
- **Reset asserted mid-DATOS of 0xC3, released, then 0x3C sent** → all outputs read reset values during reset. No `listo` for 0xC3. `datoRx`=0x3C after the next frame.
